// File: rtl/pio_pkg.sv
// Shared types and constants for the multi-port Z80-PIO-compatible controller.
package pio_pkg;

    typedef enum logic [1:0] {
        MODE_OUT   = 2'd0,
        MODE_IN    = 2'd1,
        MODE_BIDIR = 2'd2,
        MODE_BIT   = 2'd3
    } pio_mode_e;

    typedef enum logic {
        ACK_IDLE = 1'b0,
        ACK_HOLD = 1'b1
    } ack_state_e;

    // Low-nibble signatures of the control words
    localparam logic [3:0] CW_MODE   = 4'b1111;
    localparam logic [3:0] CW_INTCTL = 4'b0111;
    localparam logic [3:0] CW_INTEN  = 4'b0011;

    localparam pio_mode_e  RST_MODE   = MODE_IN;
    localparam logic [7:0] RST_VECTOR = 8'h00;
    localparam logic [7:0] DOUT_IDLE  = 8'hFF;

endpackage

// File: rtl/pio_port.sv
// One PIO port: control registers, pin/strobe synchronisers, handshake,
// bit-control condition and interrupt pending flag.
module pio_port
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [7:0]       din,
    input  logic             wr_ctrl,
    input  logic             wr_data,
    input  logic             rd_act,
    input  logic             ack_clr,
    input  logic [WIDTH-1:0] pin,
    input  logic             stb_n,
    output logic [WIDTH-1:0] port_out,
    output logic [WIDTH-1:0] port_oe,
    output logic             rdy,
    output logic             irq_c,
    output logic [7:0]       vector,
    output logic [7:0]       rd_data_c
);

    logic             stb_s1_q, stb_s1_d, stb_s2_q, stb_s2_d, stb_prev_q, stb_prev_d;
    logic [WIDTH-1:0] pin_s1_q, pin_s1_d, pin_s2_q, pin_s2_d;
    logic             cond_prev_q, cond_prev_d, rd_prev_q, rd_prev_d;
    pio_mode_e        mode_q, mode_d;
    logic             mode_set_q, mode_set_d;
    logic [WIDTH-1:0] dir_q, dir_d, mask_q, mask_d;
    logic             int_en_q, int_en_d, int_and_q, int_and_d, int_hi_q, int_hi_d;
    logic             mask_next_q, mask_next_d, dir_next_q, dir_next_d;
    logic [7:0]       vector_q, vector_d;
    logic [WIDTH-1:0] out_q, out_d, oe_q, oe_d, in_q, in_d;
    logic             rdy_q, rdy_d, pending_q, pending_d;

    pio_mode_e        mode_w_c;
    logic             stb_fall_c, stb_rise_c, rd_end_c, cond_c;
    logic [WIDTH-1:0] consider_c, level_c, hit_c;

    assign mode_w_c   = pio_mode_e'(din[7:6]);
    assign stb_fall_c = ena & stb_prev_q & ~stb_s2_q;
    assign stb_rise_c = ena & ~stb_prev_q & stb_s2_q;
    assign rd_end_c   = ena & rd_prev_q & ~rd_act;

    // Bit-control condition over unmasked input bits; empty set is false
    assign consider_c = dir_q & ~mask_q;
    assign level_c    = int_hi_q ? pin_s2_q : ~pin_s2_q;
    assign hit_c      = level_c & consider_c;
    assign cond_c     = (mode_q == MODE_BIT) && (consider_c != '0) &&
                        (int_and_q ? (hit_c == consider_c) : (hit_c != '0));

    always_comb begin
        stb_s1_d    = stb_n;
        stb_s2_d    = stb_s1_q;
        pin_s1_d    = pin;
        pin_s2_d    = pin_s1_q;
        stb_prev_d  = ena ? stb_s2_q : stb_prev_q;
        cond_prev_d = ena ? cond_c : cond_prev_q;
        rd_prev_d   = ena ? rd_act : rd_prev_q;
        mode_d      = mode_q;
        mode_set_d  = mode_set_q;
        dir_d       = dir_q;
        mask_d      = mask_q;
        int_en_d    = int_en_q;
        int_and_d   = int_and_q;
        int_hi_d    = int_hi_q;
        mask_next_d = mask_next_q;
        dir_next_d  = dir_next_q;
        vector_d    = vector_q;
        out_d       = out_q;
        in_d        = in_q;
        rdy_d       = rdy_q;
        pending_d   = pending_q & ~ack_clr;
        oe_d        = '0;

        if (wr_ctrl) begin
            if (mask_next_q) begin
                mask_d      = din[WIDTH-1:0];
                mask_next_d = 1'b0;
            end else if (dir_next_q) begin
                dir_d      = din[WIDTH-1:0];
                dir_next_d = 1'b0;
            end else if (din[3:0] == CW_MODE) begin
                if (mode_w_c != MODE_BIDIR) begin
                    mode_d     = mode_w_c;
                    mode_set_d = 1'b1;
                    rdy_d      = (mode_w_c == MODE_IN);
                    dir_next_d = (mode_w_c == MODE_BIT);
                end
            end else if (din[3:0] == CW_INTCTL) begin
                int_en_d    = din[7];
                int_and_d   = din[6];
                int_hi_d    = din[5];
                mask_next_d = din[4];
            end else if (din[3:0] == CW_INTEN) begin
                int_en_d = din[7];
            end else if (!din[0]) begin
                vector_d = {din[7:1], 1'b0};
            end
        end

        if (wr_data) begin
            out_d = din[WIDTH-1:0];
            if (mode_q == MODE_OUT) rdy_d = 1'b1;
        end

        if (rd_end_c && mode_q == MODE_IN && mode_set_q) rdy_d = 1'b1;

        // Strobe is applied after the bus access of the same cycle
        if (mode_q == MODE_OUT || mode_q == MODE_IN) begin
            if (stb_fall_c) begin
                rdy_d = 1'b0;
                if (mode_q == MODE_IN) in_d = pin_s2_q;
            end
            if (stb_rise_c && int_en_q) pending_d = 1'b1;
        end

        if (ena && cond_c && !cond_prev_q) pending_d = 1'b1;

        if (mode_d == MODE_BIT) rdy_d = 1'b0;

        case (mode_d)
            MODE_OUT: oe_d = '1;
            MODE_BIT: oe_d = ~dir_d;
            default:  oe_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_s1_q    <= 1'b1;
            stb_s2_q    <= 1'b1;
            stb_prev_q  <= 1'b1;
            pin_s1_q    <= '0;
            pin_s2_q    <= '0;
            cond_prev_q <= 1'b0;
            rd_prev_q   <= 1'b0;
            mode_q      <= RST_MODE;
            mode_set_q  <= 1'b0;
            dir_q       <= '1;
            mask_q      <= '1;
            int_en_q    <= 1'b0;
            int_and_q   <= 1'b0;
            int_hi_q    <= 1'b0;
            mask_next_q <= 1'b0;
            dir_next_q  <= 1'b0;
            vector_q    <= RST_VECTOR;
            out_q       <= '0;
            oe_q        <= '0;
            in_q        <= '0;
            rdy_q       <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            stb_s1_q    <= stb_s1_d;
            stb_s2_q    <= stb_s2_d;
            stb_prev_q  <= stb_prev_d;
            pin_s1_q    <= pin_s1_d;
            pin_s2_q    <= pin_s2_d;
            cond_prev_q <= cond_prev_d;
            rd_prev_q   <= rd_prev_d;
            mode_q      <= ena ? mode_d : mode_q;
            mode_set_q  <= ena ? mode_set_d : mode_set_q;
            dir_q       <= ena ? dir_d : dir_q;
            mask_q      <= ena ? mask_d : mask_q;
            int_en_q    <= ena ? int_en_d : int_en_q;
            int_and_q   <= ena ? int_and_d : int_and_q;
            int_hi_q    <= ena ? int_hi_d : int_hi_q;
            mask_next_q <= ena ? mask_next_d : mask_next_q;
            dir_next_q  <= ena ? dir_next_d : dir_next_q;
            vector_q    <= ena ? vector_d : vector_q;
            out_q       <= ena ? out_d : out_q;
            oe_q        <= ena ? oe_d : oe_q;
            in_q        <= ena ? in_d : in_q;
            rdy_q       <= ena ? rdy_d : rdy_q;
            pending_q   <= ena ? pending_d : pending_q;
        end
    end

    assign port_out = out_q;
    assign port_oe  = oe_q;
    assign rdy      = rdy_q;
    assign vector   = vector_q;
    assign irq_c    = pending_q & int_en_q;

    always_comb begin
        rd_data_c = 8'(out_q);
        case (mode_q)
            MODE_IN:  rd_data_c = 8'(in_q);
            MODE_BIT: rd_data_c = 8'((pin_s2_q & dir_q) | (out_q & ~dir_q));
            default:  rd_data_c = 8'(out_q);
        endcase
    end

endmodule

// File: rtl/z80pio_multi.sv
// Multi-port Z80-PIO-compatible controller: bus decode, read mux,
// interrupt priority and mode-2 acknowledge handling.
module z80pio_multi
    import pio_pkg::*;
#(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned PSW    = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                    sys_clock,
    input  logic                    reset_n,
    input  logic                    clock_ena,
    input  logic [7:0]              din,
    output logic [7:0]              dout,
    input  logic                    ce_n,
    input  logic [PSW-1:0]          port_sel,
    input  logic                    cd,
    input  logic                    m1_n,
    input  logic                    iorq_n,
    input  logic                    rd_n,
    output logic                    int_n,
    input  logic [NPORTS*WIDTH-1:0] port_in,
    output logic [NPORTS*WIDTH-1:0] port_out,
    output logic [NPORTS*WIDTH-1:0] port_oe,
    input  logic [NPORTS-1:0]       stb_n,
    output logic [NPORTS-1:0]       rdy
);

    logic             access_c, wr_c, rd_c, ack_c, sel_ok_c, wr_fire_c;
    logic             wr_seen_q, wr_seen_d;
    logic             int_n_q, int_n_d;
    ack_state_e       state_q, state_d;
    logic [PSW-1:0]   win_q, win_d, win_idx_c;
    logic             win_valid_q, win_valid_d, win_any_c;
    logic [NPORTS-1:0] irq_c, ack_clr_c;
    logic [7:0]       vec_arr [NPORTS];
    logic [7:0]       rd_arr  [NPORTS];

    assign access_c  = ~ce_n & ~iorq_n & m1_n;
    assign wr_c      = access_c & rd_n;
    assign rd_c      = access_c & ~rd_n;
    assign ack_c     = ~m1_n & ~iorq_n;
    assign sel_ok_c  = (32'(port_sel) < NPORTS);
    assign wr_fire_c = clock_ena & wr_c & ~wr_seen_q & sel_ok_c;
    assign wr_seen_d = clock_ena ? wr_c : wr_seen_q;
    assign int_n_d   = ~|irq_c;

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        pio_port #(.WIDTH(WIDTH)) u_port (
            .clk       (sys_clock),
            .rst_n     (reset_n),
            .ena       (clock_ena),
            .din       (din),
            .wr_ctrl   (wr_fire_c & cd & (port_sel == PSW'(i))),
            .wr_data   (wr_fire_c & ~cd & (port_sel == PSW'(i))),
            .rd_act    (rd_c & ~cd & (port_sel == PSW'(i))),
            .ack_clr   (ack_clr_c[i]),
            .pin       (port_in[i*WIDTH +: WIDTH]),
            .stb_n     (stb_n[i]),
            .port_out  (port_out[i*WIDTH +: WIDTH]),
            .port_oe   (port_oe[i*WIDTH +: WIDTH]),
            .rdy       (rdy[i]),
            .irq_c     (irq_c[i]),
            .vector    (vec_arr[i]),
            .rd_data_c (rd_arr[i])
        );
    end

    // Lowest index wins
    always_comb begin
        win_idx_c = '0;
        win_any_c = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (irq_c[i] && !win_any_c) begin
                win_idx_c = PSW'(i);
                win_any_c = 1'b1;
            end
        end
    end

    // Ack: latch winner on first enabled cycle, clear its pending at the end
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        win_valid_d = win_valid_q;
        ack_clr_c   = '0;
        if (clock_ena) begin
            case (state_q)
                ACK_IDLE: begin
                    if (ack_c) begin
                        state_d     = ACK_HOLD;
                        win_d       = win_idx_c;
                        win_valid_d = win_any_c;
                    end
                end
                ACK_HOLD: begin
                    if (!ack_c) begin
                        state_d     = ACK_IDLE;
                        win_valid_d = 1'b0;
                        if (win_valid_q) ack_clr_c[win_q] = 1'b1;
                    end
                end
                default: state_d = ACK_IDLE;
            endcase
        end
    end

    always_comb begin
        dout = DOUT_IDLE;
        if (ack_c) begin
            if (state_q == ACK_HOLD) begin
                if (win_valid_q) dout = vec_arr[win_q];
            end else if (win_any_c) begin
                dout = vec_arr[win_idx_c];
            end
        end else if (rd_c && sel_ok_c && !cd) begin
            dout = rd_arr[port_sel];
        end
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_seen_q   <= 1'b0;
            int_n_q     <= 1'b1;
            state_q     <= ACK_IDLE;
            win_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            wr_seen_q   <= wr_seen_d;
            int_n_q     <= int_n_d;
            state_q     <= state_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign int_n = int_n_q;

endmodule

// File: tb/tb_z80pio_multi.sv
// Randomised bench for z80pio_multi against a transaction-level PIO model.
module tb_z80pio_multi;

    localparam int NP  = 3;
    localparam int W   = 8;
    localparam int PSW = 2;

    logic              sys_clock = 1'b0;
    logic              reset_n, clock_ena;
    logic [7:0]        din, dout;
    logic              ce_n, cd, m1_n, iorq_n, rd_n, int_n;
    logic [PSW-1:0]    port_sel;
    logic [NP*W-1:0]   port_in, port_out, port_oe;
    logic [NP-1:0]     stb_n, rdy;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state, one entry per port
    int         m_mode [NP];
    bit         m_set [NP], m_en [NP], m_and [NP], m_hi [NP];
    bit         m_mnext [NP], m_dnext [NP], m_rdy [NP], m_pend [NP], m_cprev [NP];
    logic [7:0] m_dir [NP], m_mask [NP], m_vec [NP], m_out [NP], m_in [NP], m_pins [NP];

    z80pio_multi #(.NPORTS(NP), .WIDTH(W)) dut (
        .sys_clock (sys_clock),
        .reset_n   (reset_n),
        .clock_ena (clock_ena),
        .din       (din),
        .dout      (dout),
        .ce_n      (ce_n),
        .port_sel  (port_sel),
        .cd        (cd),
        .m1_n      (m1_n),
        .iorq_n    (iorq_n),
        .rd_n      (rd_n),
        .int_n     (int_n),
        .port_in   (port_in),
        .port_out  (port_out),
        .port_oe   (port_oe),
        .stb_n     (stb_n),
        .rdy       (rdy)
    );

    initial forever #5 sys_clock = ~sys_clock;

    // Enable is never low on two consecutive cycles
    initial begin
        clock_ena = 1'b1;
        forever begin
            @(negedge sys_clock);
            if (!clock_ena) clock_ena = 1'b1;
            else clock_ena = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) begin
            m_mode[p] = 1;  m_set[p] = 0;  m_en[p] = 0;  m_and[p] = 0;  m_hi[p] = 0;
            m_mnext[p] = 0; m_dnext[p] = 0; m_rdy[p] = 0; m_pend[p] = 0; m_cprev[p] = 0;
            m_dir[p] = 8'hFF; m_mask[p] = 8'hFF; m_vec[p] = 8'h00;
            m_out[p] = 8'h00; m_in[p] = 8'h00;
        end
    endfunction

    // Condition counted bit by bit over monitored input bits
    function automatic bit cond_of(int p);
        int n_mon = 0;
        int n_act = 0;
        if (m_mode[p] != 3) return 1'b0;
        for (int b = 0; b < W; b++) begin
            if (m_dir[p][b] && !m_mask[p][b]) begin
                n_mon++;
                if (m_pins[p][b] == m_hi[p]) n_act++;
            end
        end
        if (n_mon == 0) return 1'b0;
        return m_and[p] ? (n_act == n_mon) : (n_act > 0);
    endfunction

    function automatic void update_cond();
        for (int p = 0; p < NP; p++) begin
            bit c = cond_of(p);
            if (c && !m_cprev[p]) m_pend[p] = 1'b1;
            m_cprev[p] = c;
        end
    endfunction

    function automatic void model_ctrl(int p, logic [7:0] d);
        if (m_mnext[p]) begin
            m_mask[p] = d; m_mnext[p] = 0;
        end else if (m_dnext[p]) begin
            m_dir[p] = d; m_dnext[p] = 0;
        end else if (d[3:0] == 4'hF) begin
            if (int'(d[7:6]) != 2) begin
                m_mode[p]  = int'(d[7:6]);
                m_set[p]   = 1;
                m_rdy[p]   = (m_mode[p] == 1);
                m_dnext[p] = (m_mode[p] == 3);
            end
        end else if (d[3:0] == 4'h7) begin
            m_en[p] = d[7]; m_and[p] = d[6]; m_hi[p] = d[5]; m_mnext[p] = d[4];
        end else if (d[3:0] == 4'h3) begin
            m_en[p] = d[7];
        end else if (!d[0]) begin
            m_vec[p] = {d[7:1], 1'b0};
        end
    endfunction

    function automatic logic [7:0] model_read(int p, bit c);
        logic [7:0] r;
        if (p >= NP || c) return 8'hFF;
        if (m_mode[p] == 0) return m_out[p];
        if (m_mode[p] == 1) return m_in[p];
        for (int b = 0; b < 8; b++) r[b] = m_dir[p][b] ? m_pins[p][b] : m_out[p][b];
        return r;
    endfunction

    function automatic logic [7:0] model_oe(int p);
        if (m_mode[p] == 0) return 8'hFF;
        if (m_mode[p] == 3) return ~m_dir[p];
        return 8'h00;
    endfunction

    task automatic bus_idle();
        ce_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; cd = 1'b0;
        port_sel = '0; din = 8'h00;
    endtask

    task automatic do_write(input int p, input bit c, input logic [7:0] d);
        @(negedge sys_clock);
        port_sel = 2'(p); cd = c; din = d; rd_n = 1'b1; m1_n = 1'b1;
        ce_n = 1'b0; iorq_n = 1'b0;
        repeat (4) @(negedge sys_clock);
        bus_idle();
        repeat (3) @(negedge sys_clock);
        if (p < NP) begin
            if (c) model_ctrl(p, d);
            else begin
                m_out[p] = d;
                if (m_mode[p] == 0) m_rdy[p] = 1'b1;
            end
        end
        update_cond();
    endtask

    task automatic do_read(input int p, input bit c);
        @(negedge sys_clock);
        port_sel = 2'(p); cd = c; rd_n = 1'b0; m1_n = 1'b1; ce_n = 1'b0; iorq_n = 1'b0;
        repeat (2) @(negedge sys_clock);
        chk_eq("read_data", 32'(dout), 32'(model_read(p, c)));
        repeat (2) @(negedge sys_clock);
        bus_idle();
        repeat (4) @(negedge sys_clock);
        if (p < NP && !c && m_mode[p] == 1 && m_set[p]) m_rdy[p] = 1'b1;
    endtask

    task automatic set_pins(input int p, input logic [7:0] v);
        @(negedge sys_clock);
        m_pins[p] = v;
        port_in[p*W +: W] = v;
        repeat (6) @(negedge sys_clock);
        update_cond();
    endtask

    task automatic do_strobe(input int p);
        @(negedge sys_clock);
        stb_n[p] = 1'b0;
        repeat (8) @(negedge sys_clock);
        stb_n[p] = 1'b1;
        repeat (8) @(negedge sys_clock);
        if (m_mode[p] == 0 || m_mode[p] == 1) begin
            if (m_mode[p] == 1) m_in[p] = m_pins[p];
            m_rdy[p] = 1'b0;
            if (m_en[p]) m_pend[p] = 1'b1;
        end
    endtask

    task automatic do_ack(output logic [7:0] got);
        int w = -1;
        logic [7:0] exp = 8'hFF;
        for (int p = NP - 1; p >= 0; p--) if (m_pend[p] && m_en[p]) w = p;
        if (w >= 0) exp = m_vec[w];
        @(negedge sys_clock);
        ce_n = 1'b1; m1_n = 1'b0; iorq_n = 1'b0;
        repeat (3) @(negedge sys_clock);
        got = dout;
        chk_eq("ack_vector", 32'(got), 32'(exp));
        @(negedge sys_clock);
        bus_idle();
        repeat (4) @(negedge sys_clock);
        if (w >= 0) m_pend[w] = 1'b0;
        update_cond();
    endtask

    task automatic check_outputs();
        logic [NP*W-1:0] e_out, e_oe;
        logic [NP-1:0]   e_rdy;
        bit              e_irq = 1'b0;
        for (int p = 0; p < NP; p++) begin
            e_out[p*W +: W] = m_out[p];
            e_oe[p*W +: W]  = model_oe(p);
            e_rdy[p]        = m_rdy[p];
            if (m_pend[p] && m_en[p]) e_irq = 1'b1;
        end
        chk_eq("port_out", 32'(port_out), 32'(e_out));
        chk_eq("port_oe", 32'(port_oe), 32'(e_oe));
        chk_eq("rdy", 32'(rdy), 32'(e_rdy));
        chk_eq("int_n", 32'(int_n), 32'(!e_irq));
        chk_eq("dout_idle", 32'(dout), 32'hFF);
    endtask

    logic [7:0] ack_val;
    logic [7:0] rnd;

    initial begin
        reset_n = 1'b0;
        bus_idle();
        stb_n   = '1;
        port_in = '0;
        for (int p = 0; p < NP; p++) m_pins[p] = 8'h00;
        model_reset();
        repeat (3) @(negedge sys_clock);
        check_outputs();
        reset_n = 1'b1;
        repeat (2) @(negedge sys_clock);

        // Port 0 output handshake
        do_write(0, 1'b1, 8'h0F);
        do_write(0, 1'b0, 8'hA5);
        check_outputs();
        chk_eq("p0_out_a5", 32'(port_out[7:0]), 32'hA5);
        do_strobe(0);
        check_outputs();

        // Port 1 input handshake
        do_write(1, 1'b1, 8'h4F);
        set_pins(1, 8'h3C);
        do_strobe(1);
        check_outputs();
        do_read(1, 1'b0);
        check_outputs();

        // Two-port interrupt priority
        do_write(0, 1'b1, 8'h20);
        do_write(1, 1'b1, 8'h30);
        do_write(0, 1'b1, 8'h83);
        do_write(1, 1'b1, 8'h83);
        do_strobe(0);
        do_strobe(1);
        check_outputs();
        do_ack(ack_val);
        chk_eq("ack_first_20", 32'(ack_val), 32'h20);
        do_ack(ack_val);
        chk_eq("ack_second_30", 32'(ack_val), 32'h30);
        check_outputs();

        // Port 2 bit control, AND active-high on upper nibble
        do_write(2, 1'b1, 8'hCF);
        do_write(2, 1'b1, 8'hF0);
        do_write(2, 1'b1, 8'hF7);
        do_write(2, 1'b1, 8'h0F);
        do_write(2, 1'b1, 8'h40);
        check_outputs();
        set_pins(2, 8'hF0);
        check_outputs();
        do_ack(ack_val);
        set_pins(2, 8'hE0);
        check_outputs();
        do_read(2, 1'b0);

        // Out-of-range port select
        do_write(3, 1'b0, 8'h55);
        do_write(3, 1'b1, 8'h0F);
        check_outputs();
        do_read(3, 1'b0);

        // Random traffic
        for (int k = 0; k < 220; k++) begin
            int p = $urandom_range(0, NP);
            int q = $urandom_range(0, NP - 1);
            case ($urandom_range(0, 8))
                0, 1: begin
                    case ($urandom_range(0, 9))
                        0: rnd = 8'h0F;
                        1: rnd = 8'h4F;
                        2: rnd = 8'hCF;
                        3: rnd = 8'h97;
                        4: rnd = 8'h87;
                        5: rnd = 8'hB7;
                        6: rnd = 8'h83;
                        7: rnd = 8'h8F;
                        default: rnd = 8'($urandom);
                    endcase
                    do_write(p, 1'b1, rnd);
                end
                2: do_write(p, 1'b0, 8'($urandom));
                3: do_read(p, 1'($urandom_range(0, 1)));
                4, 5: begin
                    set_pins(q, 8'($urandom));
                    do_strobe(q);
                end
                6: set_pins(q, 8'($urandom));
                7: do_ack(ack_val);
                default: do_read(q, 1'b0);
            endcase
            check_outputs();
        end

        // Reset in the middle of a port-0 handshake
        do_write(0, 1'b1, 8'h0F);
        do_write(0, 1'b0, 8'h5A);
        @(negedge sys_clock);
        stb_n[0] = 1'b0;
        repeat (3) @(negedge sys_clock);
        #2 reset_n = 1'b0;
        #1;
        chk_eq("rst_port_out", 32'(port_out), 32'h0);
        chk_eq("rst_port_oe", 32'(port_oe), 32'h0);
        chk_eq("rst_rdy", 32'(rdy), 32'h0);
        chk_eq("rst_int_n", 32'(int_n), 32'h1);
        chk_eq("rst_dout", 32'(dout), 32'hFF);
        stb_n = '1;
        repeat (3) @(negedge sys_clock);
        reset_n = 1'b1;
        model_reset();
        update_cond();
        repeat (4) @(negedge sys_clock);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
